conv_encoder_puncturer: RTL



---
 rtl/conv_enc_pkg.sv | 47 ++++
 rtl/conv_enc_core.sv | 18 +
 rtl/conv_encoder_puncturer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/conv_enc_pkg.sv
// Shared constants and puncturing helpers for the K=7 rate-1/2 mother-code encoder.
package conv_enc_pkg;

   localparam int unsigned K       = 7;
   localparam int unsigned STATE_W = K - 1;
   localparam int unsigned RATE_W  = 2;
   localparam int unsigned PHASE_W = 2;

   localparam logic [RATE_W-1:0] RATE_1_2 = 2'b00;
   localparam logic [RATE_W-1:0] RATE_2_3 = 2'b01;
   localparam logic [RATE_W-1:0] RATE_3_4 = 2'b10;

   localparam logic [K-1:0] G0_DEFAULT = 7'b1011011;
   localparam logic [K-1:0] G1_DEFAULT = 7'b1111001;

   // {keepA, keepB} for the given rate and puncturing phase
   function automatic logic [1:0] keep_mask(input logic [RATE_W-1:0] rate,
                                            input logic [PHASE_W-1:0] phase);
      logic [1:0] keep;
      keep = 2'b11;
      case (rate)
         RATE_2_3: keep = (phase == 2'd0) ? 2'b11 : 2'b10;
         RATE_3_4: begin
            case (phase)
               2'd0:    keep = 2'b11;
               2'd1:    keep = 2'b10;
               default: keep = 2'b01;
            endcase
         end
         default:  keep = 2'b11;
      endcase
      return keep;
   endfunction

   // Last phase value before the puncturing pattern wraps
   function automatic logic [PHASE_W-1:0] phase_max(input logic [RATE_W-1:0] rate);
      logic [PHASE_W-1:0] pmax;
      pmax = 2'd0;
      case (rate)
         RATE_2_3: pmax = 2'd1;
         RATE_3_4: pmax = 2'd2;
         default:  pmax = 2'd0;
      endcase
      return pmax;
   endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational parity generator: coded_c = {A, B} for window {in_bit, state}.
module conv_enc_core
   import conv_enc_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEFAULT,
   parameter logic [K-1:0] G1 = G1_DEFAULT
) (
   input  logic               in_bit,
   input  logic [STATE_W-1:0] state,
   output logic [1:0]         coded_c
);

   logic [K-1:0] window_c;

   assign window_c = {in_bit, state};
   assign coded_c  = {^(window_c & G0), ^(window_c & G1)};

endmodule

// File: rtl/conv_encoder_puncturer.sv
// K=7 convolutional encoder with 1/2, 2/3, 3/4 puncturing and a two-bit serial output buffer.
// Optional zero-tail insertion with InLast/OutLast when CONV_ENC_TAIL_EN is defined.
module conv_encoder_puncturer
   import conv_enc_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEFAULT,
   parameter logic [K-1:0] G1 = G1_DEFAULT
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              FrameStart,
   input  logic [RATE_W-1:0] Rate,
   input  logic              InValid,
   output logic              InReady,
   input  logic              InBit,
`ifdef CONV_ENC_TAIL_EN
   input  logic              InLast,
   output logic              OutLast,
`endif
   output logic              OutValid,
   input  logic              OutReady,
   output logic              OutBit
);

   localparam int unsigned PEND_W = 2;

   logic [STATE_W-1:0] state_q, state_n;
   logic [PHASE_W-1:0] phase_q, phase_n;
   logic [RATE_W-1:0]  rate_q;
   logic [PEND_W-1:0]  pend_q, pend_n;
   logic [1:0]         pend_bits_q, pend_bits_n;
   logic [1:0]         coded_c;
   logic [1:0]         keep_c;
   logic               space_c;
   logic               pop_c;
   logic               enc_go_c;
   logic               enc_bit_c;
   logic               tail_busy_c;

   conv_enc_core #(.G0(G0), .G1(G1)) u_core (
      .in_bit  (enc_bit_c),
      .state   (state_q),
      .coded_c (coded_c)
   );

   // Room for a new pair once the buffer is empty or its last bit leaves this cycle
   assign space_c   = (pend_q == 2'd0) || ((pend_q == 2'd1) && OutReady);
   assign pop_c     = (pend_q != 2'd0) && OutReady;
   assign InReady   = !FrameStart && space_c && !tail_busy_c;
   assign enc_go_c  = !FrameStart && space_c && (tail_busy_c || InValid);
   assign enc_bit_c = tail_busy_c ? 1'b0 : InBit;
   assign keep_c    = keep_mask(rate_q, phase_q);

   always_comb begin
      pend_n      = pend_q;
      pend_bits_n = pend_bits_q;
      state_n     = state_q;
      phase_n     = phase_q;
      if (pop_c) begin
         pend_n      = pend_q - 2'd1;
         pend_bits_n = {1'b0, pend_bits_q[1]};
      end
      // An encode only happens when the buffer drains this cycle, so it overwrites
      if (enc_go_c) begin
         state_n = {enc_bit_c, state_q[STATE_W-1:1]};
         phase_n = (phase_q == phase_max(rate_q)) ? '0 : phase_q + 2'd1;
         case (keep_c)
            2'b11: begin
               pend_n      = 2'd2;
               pend_bits_n = {coded_c[0], coded_c[1]};
            end
            2'b10: begin
               pend_n      = 2'd1;
               pend_bits_n = {1'b0, coded_c[1]};
            end
            default: begin
               pend_n      = 2'd1;
               pend_bits_n = {1'b0, coded_c[0]};
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q     <= '0;
         phase_q     <= '0;
         rate_q      <= RATE_1_2;
         pend_q      <= '0;
         pend_bits_q <= '0;
         OutValid    <= 1'b0;
         OutBit      <= 1'b0;
      end else if (FrameStart) begin
         state_q     <= '0;
         phase_q     <= '0;
         rate_q      <= ((Rate == RATE_2_3) || (Rate == RATE_3_4)) ? Rate : RATE_1_2;
         pend_q      <= '0;
         pend_bits_q <= '0;
         OutValid    <= 1'b0;
         OutBit      <= 1'b0;
      end else begin
         state_q     <= state_n;
         phase_q     <= phase_n;
         pend_q      <= pend_n;
         pend_bits_q <= pend_bits_n;
         OutValid    <= (pend_n != 2'd0);
         OutBit      <= pend_bits_n[0];
      end
   end

`ifdef CONV_ENC_TAIL_EN
   localparam int unsigned TAIL_W = 3;
   localparam logic [TAIL_W-1:0] TAIL_LEN = TAIL_W'(STATE_W);

   logic [TAIL_W-1:0] tail_q, tail_n;
   logic [1:0]        last_q, last_n;
   logic              tail_final_c;

   assign tail_busy_c = (tail_q != '0);

   // Last-bit flags travel alongside the pending coded bits
   always_comb begin
      tail_n       = tail_q;
      last_n       = last_q;
      tail_final_c = tail_busy_c && (tail_q == 3'd1);
      if (pop_c) begin
         last_n = {1'b0, last_q[1]};
      end
      if (enc_go_c) begin
         if (tail_busy_c) begin
            tail_n = tail_q - 3'd1;
         end else if (InLast) begin
            tail_n = TAIL_LEN;
         end
         last_n = (keep_c == 2'b11) ? {tail_final_c, 1'b0} : {1'b0, tail_final_c};
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset || FrameStart) begin
         tail_q  <= '0;
         last_q  <= '0;
         OutLast <= 1'b0;
      end else begin
         tail_q  <= tail_n;
         last_q  <= last_n;
         OutLast <= last_n[0];
      end
   end
`else
   assign tail_busy_c = 1'b0;
`endif

endmodule
